// File: rtl/ev_id_scheduler.sv
// ev_id_scheduler
//   Allocates event IDs to NREQ requesters and forwards start/end events to a
//   single event timestamper. A free bitmap tracks which IDs are in use. The
//   lowest free ID is handed to the round-robin start winner in the same cycle.
//   Accepted starts and ends each pass through a one-deep output register
//   toward the timestamper. An ID returns to the pool on the ts_end handshake.
//
// Optional feature (macro EV_OWNER_CHECK_EN):
//   When this macro is defined, an owner table records which requester was
//   granted each ID. An end from any other requester is then consumed and
//   flagged as an error. When the macro is undefined, the owner table is not
//   built, and only the unallocated-ID check drops ends.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_start_valid/ready    per-requester start handshake (ready one-hot)
//   req_start_id             ID granted to the requester whose ready is high
//   req_end_valid/ready      per-requester end handshake (ready one-hot)
//   req_end_id               end ID of requester i in [i*ID_W +: ID_W]
//   ts_start_valid/ready/id  start channel to the timestamper
//   ts_end_valid/ready/id    end channel to the timestamper
//   active_cnt               number of allocated IDs
//   ids_full                 no free ID left
//   err_pulse                one-cycle flag, one cycle after an end is dropped
module ev_id_scheduler #(
  parameter int NREQ = 4,
  parameter int ID_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_start_valid,
  output logic [NREQ-1:0]      req_start_ready,
  output logic [ID_W-1:0]      req_start_id,
  input  logic [NREQ-1:0]      req_end_valid,
  input  logic [NREQ*ID_W-1:0] req_end_id,
  output logic [NREQ-1:0]      req_end_ready,
  output logic                 ts_start_valid,
  input  logic                 ts_start_ready,
  output logic [ID_W-1:0]      ts_start_id,
  output logic                 ts_end_valid,
  input  logic                 ts_end_ready,
  output logic [ID_W-1:0]      ts_end_id,
  output logic [ID_W:0]        active_cnt,
  output logic                 ids_full,
  output logic                 err_pulse
);

  localparam int NIDS = 2 ** ID_W;
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Round-robin pick: {found, index} of the first set bit at or after ptr.
  // The loop runs downward so that the smallest distance from ptr wins.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] vld,
                                          input logic [PW-1:0]   ptr);
    logic [PW:0]   res;
    logic [PW-1:0] idx;
    int            pos;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      idx = PW'((pos >= NREQ) ? pos - NREQ : pos);
      res = vld[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  // Lowest-index set bit of the free bitmap. The result is 0 when no bit is set.
  function automatic logic [ID_W-1:0] lowest_free(input logic [NIDS-1:0] fr);
    logic [ID_W-1:0] res;
    res = '0;
    for (int k = NIDS - 1; k >= 0; k--) begin
      res = fr[k] ? ID_W'(k) : res;
    end
    return res;
  endfunction

  // Pointer value after granting index g (wraps at NREQ).
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
    return (g == PW'(NREQ - 1)) ? '0 : g + PW'(1);
  endfunction

  logic [NIDS-1:0] free_q, free_d;
  logic [PW-1:0]   st_ptr_q, st_ptr_d, en_ptr_q, en_ptr_d;
  logic            st_valid_q, st_valid_d, en_valid_q, en_valid_d;
  logic [ID_W-1:0] st_id_q, st_id_d, en_id_q, en_id_d;
  logic [ID_W:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
`ifdef EV_OWNER_CHECK_EN
  logic [PW-1:0]   owner_q [NIDS];
  logic [PW-1:0]   owner_d [NIDS];
`endif

  logic [PW:0]     st_pick, en_pick;
  logic            st_accept, en_take, en_fwd, en_drop, en_release;
  logic [ID_W-1:0] alloc_id;
  logic [ID_W-1:0] end_ids [NREQ];
  logic [NREQ-1:0] end_bad, end_elig;

  // Per-requester end classification: bad ends are dropped, so they need no
  // free end slot. An end matching the pending start ID is held back.
  always_comb begin
    end_bad  = '0;
    end_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      end_ids[i] = req_end_id[i*ID_W +: ID_W];
`ifdef EV_OWNER_CHECK_EN
      end_bad[i] = free_q[end_ids[i]] | (owner_q[end_ids[i]] != PW'(i));
`else
      end_bad[i] = free_q[end_ids[i]];
`endif
      end_elig[i] = req_end_valid[i]
                  & ~(st_valid_q & (end_ids[i] == st_id_q))
                  & (end_bad[i] | ~en_valid_q | ts_end_ready);
    end
  end

  // Arbitration and handshake outputs. Both ready vectors are forced low
  // during reset.
  always_comb begin
    req_start_ready = '0;
    req_end_ready   = '0;
    st_pick    = rr_pick(req_start_valid, st_ptr_q);
    alloc_id   = lowest_free(free_q);
    st_accept  = ~rst & st_pick[PW] & (|free_q) & (~st_valid_q | ts_start_ready);
    en_pick    = rr_pick(end_elig, en_ptr_q);
    en_take    = ~rst & en_pick[PW];
    en_drop    = en_take & end_bad[en_pick[PW-1:0]];
    en_fwd     = en_take & ~end_bad[en_pick[PW-1:0]];
    // Releasing only a currently allocated ID keeps the count exact even if a
    // stale duplicate end reaches the timestamper.
    en_release = en_valid_q & ts_end_ready & ~free_q[en_id_q];
    req_start_id = alloc_id;
    if (st_accept) begin
      req_start_ready[st_pick[PW-1:0]] = 1'b1;
    end else begin
      req_start_ready = '0;
    end
    if (en_take) begin
      req_end_ready[en_pick[PW-1:0]] = 1'b1;
    end else begin
      req_end_ready = '0;
    end
  end

  // Next-state logic for the bitmap, the counters and both output registers.
  // An ID released here is not allocatable until the bitmap flop updates.
  always_comb begin
    free_d = free_q;
    free_d[en_id_q]  = en_release ? 1'b1 : free_q[en_id_q];
    free_d[alloc_id] = st_accept  ? 1'b0 : free_d[alloc_id];

    case ({st_accept, en_release})
      2'b10:   cnt_d = cnt_q + (ID_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (ID_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    if (st_accept) begin
      st_valid_d = 1'b1;
      st_id_d    = alloc_id;
    end else if (ts_start_ready) begin
      st_valid_d = 1'b0;
      st_id_d    = st_id_q;
    end else begin
      st_valid_d = st_valid_q;
      st_id_d    = st_id_q;
    end

    if (en_fwd) begin
      en_valid_d = 1'b1;
      en_id_d    = end_ids[en_pick[PW-1:0]];
    end else if (ts_end_ready) begin
      en_valid_d = 1'b0;
      en_id_d    = en_id_q;
    end else begin
      en_valid_d = en_valid_q;
      en_id_d    = en_id_q;
    end

    st_ptr_d = st_accept ? next_ptr(st_pick[PW-1:0]) : st_ptr_q;
    en_ptr_d = en_take   ? next_ptr(en_pick[PW-1:0]) : en_ptr_q;
    err_d    = en_drop;
  end

  // State registers; reset drops any pending start/end immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_q     <= '1;
      st_ptr_q   <= '0;
      en_ptr_q   <= '0;
      st_valid_q <= 1'b0;
      st_id_q    <= '0;
      en_valid_q <= 1'b0;
      en_id_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      free_q     <= free_d;
      st_ptr_q   <= st_ptr_d;
      en_ptr_q   <= en_ptr_d;
      st_valid_q <= st_valid_d;
      st_id_q    <= st_id_d;
      en_valid_q <= en_valid_d;
      en_id_q    <= en_id_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

`ifdef EV_OWNER_CHECK_EN
  // Owner table next state: record the start winner against the granted ID.
  always_comb begin
    for (int k = 0; k < NIDS; k++) begin
      owner_d[k] = (st_accept && (alloc_id == ID_W'(k))) ? st_pick[PW-1:0] : owner_q[k];
    end
  end

  // Owner table register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NIDS; k++) owner_q[k] <= '0;
    end else begin
      for (int k = 0; k < NIDS; k++) owner_q[k] <= owner_d[k];
    end
  end
`endif

  assign ts_start_valid = st_valid_q;
  assign ts_start_id    = st_id_q;
  assign ts_end_valid   = en_valid_q;
  assign ts_end_id      = en_id_q;
  assign active_cnt     = cnt_q;
  assign ids_full       = (cnt_q == (ID_W+1)'(NIDS));
  assign err_pulse      = err_q;

endmodule
